nav_msg_gen: RTL and testbench

Navigation-data bit generator feeding the `msg_in` input of `gps_gen_core`. It produces the 50 bit/s GPS data stream, aligned so that every data bit spans exactly 20 C/A-code epochs. Each 30-bit word comes from one of two sources: an external serial source, or one of four built-in preset patterns.

---
 rtl/nav_msg_gen_if.sv | 27 ++
 rtl/nav_msg_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_nav_msg_gen.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nav_msg_gen_if.sv
// nav_msg_gen_if: groups the control inputs and data/strobe outputs of
// nav_msg_gen into one bundle.
//   master : the driver of the generator (controller or bench)
//   slave  : the generator itself
// Signals keep the generator's port names so waveforms read the same.
interface nav_msg_gen_if;
    logic       ena_in;
    logic       run_in;
    logic       epoch_in;
    logic       use_msg_preset_in;
    logic [1:0] preset_sel_in;
    logic       ext_bit_in;
    logic       msg_out;
    logic       bit_req_out;
    logic       bit_strobe_out;
    logic       word_strobe_out;

    modport master (
        output ena_in, run_in, epoch_in, use_msg_preset_in, preset_sel_in, ext_bit_in,
        input  msg_out, bit_req_out, bit_strobe_out, word_strobe_out
    );

    modport slave (
        input  ena_in, run_in, epoch_in, use_msg_preset_in, preset_sel_in, ext_bit_in,
        output msg_out, bit_req_out, bit_strobe_out, word_strobe_out
    );
endinterface

// File: rtl/nav_msg_gen.sv
// nav_msg_gen: 50 bit/s GPS navigation-bit generator for gps_gen_core.msg_in.
// Each data bit spans EPOCHS_PER_BIT qualified C/A epochs (ena_in & epoch_in).
// Words of WORD_BITS bits come either from ext_bit_in (requested through
// bit_req_out) or from one of four presets: zeros, alternating, TLM
// preamble, PN9 (x^9+x^5+1, seed 9'h1FF).
// Ports:
//   clk_in, rst_in     clock, asynchronous active-high reset
//   bus (slave)        ena/run/epoch/source controls in; msg_out,
//                      bit_req_out (comb), bit_strobe_out, word_strobe_out out
// Optional feature: define NAV_PARITY_EN (with WORD_BITS = 30) to replace
// bits 24..29 with GPS parity D25..D30 and send bits 0..23 XORed with D30*.
module nav_msg_gen #(
    parameter int EPOCHS_PER_BIT = 20,
    parameter int WORD_BITS      = 30
) (
    input  logic           clk_in,
    input  logic           rst_in,
    nav_msg_gen_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    localparam logic [4:0] EPB_LAST   = 5'(EPOCHS_PER_BIT - 1);
    localparam logic [4:0] WB_LAST    = 5'(WORD_BITS - 1);
    localparam logic [8:0] LFSR_SEED  = 9'h1FF;
    // Preamble 1,0,0,0,1,0,1,1 with bit k of the word at index k.
    localparam logic [7:0] PREAMBLE   = 8'b1101_0001;

    state_t     state_q, state_d;
    logic [4:0] epoch_cnt_q, epoch_cnt_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic       msg_q, msg_d;
    logic       bit_strobe_q, bit_strobe_d;
    logic       word_strobe_q, word_strobe_d;
    logic       src_ext_q, src_ext_d;
    logic [1:0] preset_q, preset_d;
    logic [8:0] lfsr_q, lfsr_d;

    logic       qe;
    logic       issue;
    logic [4:0] bit_idx;
    logic       word_start;
    logic       src_ext;
    logic [1:0] sel;
    logic       preset_bit;
    logic       raw_bit;
    logic       tx_bit;

`ifdef NAV_PARITY_EN
    logic [23:0] data_q, data_d;   // raw source bits d1..d24 of the current word
    logic        d29s_q, d29s_d;
    logic        d30s_q, d30s_d;
    logic [5:0]  par;              // par[0] = D25 ... par[5] = D30

    assign par[0] = d29s_q ^ data_q[0] ^ data_q[1] ^ data_q[2] ^ data_q[4] ^ data_q[5] ^ data_q[9]
                  ^ data_q[10] ^ data_q[11] ^ data_q[12] ^ data_q[13] ^ data_q[16] ^ data_q[17]
                  ^ data_q[19] ^ data_q[22];
    assign par[1] = d30s_q ^ data_q[1] ^ data_q[2] ^ data_q[3] ^ data_q[5] ^ data_q[6] ^ data_q[10]
                  ^ data_q[11] ^ data_q[12] ^ data_q[13] ^ data_q[14] ^ data_q[17] ^ data_q[18]
                  ^ data_q[20] ^ data_q[23];
    assign par[2] = d29s_q ^ data_q[0] ^ data_q[2] ^ data_q[3] ^ data_q[4] ^ data_q[6] ^ data_q[7]
                  ^ data_q[11] ^ data_q[12] ^ data_q[13] ^ data_q[14] ^ data_q[15] ^ data_q[18]
                  ^ data_q[19] ^ data_q[21];
    assign par[3] = d30s_q ^ data_q[1] ^ data_q[3] ^ data_q[4] ^ data_q[5] ^ data_q[7] ^ data_q[8]
                  ^ data_q[12] ^ data_q[13] ^ data_q[14] ^ data_q[15] ^ data_q[16] ^ data_q[19]
                  ^ data_q[20] ^ data_q[22];
    assign par[4] = d30s_q ^ data_q[0] ^ data_q[2] ^ data_q[4] ^ data_q[5] ^ data_q[6] ^ data_q[8]
                  ^ data_q[9] ^ data_q[13] ^ data_q[14] ^ data_q[15] ^ data_q[16] ^ data_q[17]
                  ^ data_q[20] ^ data_q[21] ^ data_q[23];
    assign par[5] = d29s_q ^ data_q[2] ^ data_q[4] ^ data_q[5] ^ data_q[7] ^ data_q[8] ^ data_q[9]
                  ^ data_q[10] ^ data_q[12] ^ data_q[14] ^ data_q[18] ^ data_q[21] ^ data_q[22]
                  ^ data_q[23];
`endif

    assign qe = bus.ena_in & bus.epoch_in;

    always_comb begin
        state_d       = state_q;
        epoch_cnt_d   = epoch_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        msg_d         = msg_q;
        bit_strobe_d  = 1'b0;
        word_strobe_d = 1'b0;
        src_ext_d     = src_ext_q;
        preset_d      = preset_q;
        lfsr_d        = lfsr_q;
        issue         = 1'b0;
        bit_idx       = '0;
`ifdef NAV_PARITY_EN
        data_d        = data_q;
        d29s_d        = d29s_q;
        d30s_d        = d30s_q;
`endif

        if (bus.ena_in) begin
            if (!bus.run_in) begin
                // Abort wins over a simultaneous qualified epoch.
                state_d     = IDLE;
                epoch_cnt_d = '0;
                bit_cnt_d   = '0;
                msg_d       = 1'b0;
                lfsr_d      = LFSR_SEED;
`ifdef NAV_PARITY_EN
                data_d      = '0;
                d29s_d      = 1'b0;
                d30s_d      = 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: state_d = SYNC;
                    SYNC: begin
                        if (qe) begin
                            state_d     = RUN;
                            epoch_cnt_d = '0;
                            issue       = 1'b1;
                        end
                    end
                    RUN: begin
                        if (qe) begin
                            if (epoch_cnt_q == EPB_LAST) begin
                                epoch_cnt_d = '0;
                                issue       = 1'b1;
                                bit_idx     = (bit_cnt_q == WB_LAST) ? 5'd0 : bit_cnt_q + 5'd1;
                            end else begin
                                epoch_cnt_d = epoch_cnt_q + 5'd1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        // Source and preset are taken live only for bit 0; the rest of the
        // word uses the copy latched at that moment.
        word_start = issue & (bit_idx == 5'd0);
        src_ext    = word_start ? ~bus.use_msg_preset_in : src_ext_q;
        sel        = word_start ? bus.preset_sel_in      : preset_q;

        case (sel)
            2'd0:    preset_bit = 1'b0;
            2'd1:    preset_bit = ~bit_idx[0];
            2'd2:    preset_bit = (bit_idx < 5'd8) ? PREAMBLE[bit_idx[2:0]] : 1'b0;
            default: preset_bit = lfsr_q[8];
        endcase

        raw_bit = src_ext ? bus.ext_bit_in : preset_bit;
        tx_bit  = raw_bit;

        if (issue) begin
`ifdef NAV_PARITY_EN
            if (bit_idx < 5'd24) begin
                tx_bit          = raw_bit ^ d30s_q;
                data_d[bit_idx] = raw_bit;
            end else begin
                case (bit_idx)
                    5'd24:   tx_bit = par[0];
                    5'd25:   tx_bit = par[1];
                    5'd26:   tx_bit = par[2];
                    5'd27:   tx_bit = par[3];
                    5'd28:   tx_bit = par[4];
                    5'd29:   tx_bit = par[5];
                    default: tx_bit = raw_bit;
                endcase
            end
            // D29*/D30* for the next word become valid once D30 goes out.
            if (bit_idx == 5'd29) begin
                d29s_d = par[4];
                d30s_d = par[5];
            end
`endif
            bit_cnt_d     = bit_idx;
            msg_d         = tx_bit;
            bit_strobe_d  = 1'b1;
            word_strobe_d = word_start;
            src_ext_d     = src_ext;
            preset_d      = sel;
            // The PN9 sequence steps on every issued bit, whatever the source.
            lfsr_d        = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            epoch_cnt_q   <= '0;
            bit_cnt_q     <= '0;
            msg_q         <= 1'b0;
            bit_strobe_q  <= 1'b0;
            word_strobe_q <= 1'b0;
            src_ext_q     <= 1'b0;
            preset_q      <= '0;
            lfsr_q        <= LFSR_SEED;
`ifdef NAV_PARITY_EN
            data_q        <= '0;
            d29s_q        <= 1'b0;
            d30s_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            epoch_cnt_q   <= epoch_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            msg_q         <= msg_d;
            bit_strobe_q  <= bit_strobe_d;
            word_strobe_q <= word_strobe_d;
            src_ext_q     <= src_ext_d;
            preset_q      <= preset_d;
            lfsr_q        <= lfsr_d;
`ifdef NAV_PARITY_EN
            data_q        <= data_d;
            d29s_q        <= d29s_d;
            d30s_q        <= d30s_d;
`endif
        end
    end

    assign bus.msg_out         = msg_q;
    assign bus.bit_req_out     = issue & src_ext;
    assign bus.bit_strobe_out  = bit_strobe_q;
    assign bus.word_strobe_out = word_strobe_q;

endmodule

// File: tb/tb_nav_msg_gen.sv
// Bench for nav_msg_gen: constant vector table for the first bits of each
// source, hand-written corner sequences, and a randomized run checked every
// cycle against a word/bit-count reference model.
module tb_nav_msg_gen;
    localparam int EPB = 20;
    localparam int WB  = 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    nav_msg_gen_if bus ();

    nav_msg_gen #(.EPOCHS_PER_BIT(EPB), .WORD_BITS(WB)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  pre_tab [8]     = '{1, 0, 0, 0, 1, 0, 1, 1};
    int  ptab    [6][15] = '{
        '{1, 2, 3, 5, 6, 10, 11, 12, 13, 14, 17, 18, 20, 23, 0},
        '{2, 3, 4, 6, 7, 11, 12, 13, 14, 15, 18, 19, 21, 24, 0},
        '{1, 3, 4, 5, 7, 8, 12, 13, 14, 15, 16, 19, 20, 22, 0},
        '{2, 4, 5, 6, 8, 9, 13, 14, 15, 16, 17, 20, 21, 23, 0},
        '{1, 3, 5, 6, 7, 9, 10, 14, 15, 16, 17, 18, 21, 22, 24},
        '{3, 5, 6, 8, 9, 10, 11, 13, 15, 19, 22, 23, 24, 0, 0}};
    int  pstar   [6]     = '{29, 30, 29, 30, 30, 29};

    int  m_state;        // 0 idle, 1 sync, 2 run
    int  m_n;            // qualified epochs since the first bit of the run
    int  m_bits;         // bits issued since leaving idle
    bit  m_ext;
    int  m_sel;
    bit  e_msg, e_bs, e_ws;
    bit  m_d [24];
    bit  m_d29, m_d30;
    bit  req_seen;

    bit  g_up, g_run, g_ext;
    logic [1:0] g_sel;

    function automatic bit pn9_bit(input int idx);
        logic [8:0] s;
        s = 9'h1FF;
        for (int i = 0; i < idx; i++) s = {s[7:0], s[8] ^ s[4]};
        return s[8];
    endfunction

    function automatic bit preset_bit(input int sel, input int k, input int pn_idx);
        case (sel)
            0:       return 1'b0;
            1:       return (k % 2) == 0;
            2:       return (k < 8) ? bit'(pre_tab[k]) : 1'b0;
            default: return pn9_bit(pn_idx);
        endcase
    endfunction

    // j = 1..6 gives D25..D30
    function automatic bit par_bit(input int j);
        bit p;
        p = (pstar[j-1] == 29) ? m_d29 : m_d30;
        for (int i = 0; i < 15; i++)
            if (ptab[j-1][i] != 0) p ^= m_d[ptab[j-1][i] - 1];
        return p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_n = 0; m_bits = 0; m_ext = 0; m_sel = 0;
        e_msg = 0; e_bs = 0; e_ws = 0; m_d29 = 0; m_d30 = 0;
        for (int i = 0; i < 24; i++) m_d[i] = 0;
    endtask

    // One clock: drive inputs, check the combinational request, clock,
    // then check the registered outputs against the model.
    task automatic cyc(input bit ena, input bit run, input bit ep, input bit up,
                       input logic [1:0] sel, input bit ext);
        bit issue, sx, raw, tx, p29, p30;
        int n, k, ss;
        bus.ena_in = ena; bus.run_in = run; bus.epoch_in = ep;
        bus.use_msg_preset_in = up; bus.preset_sel_in = sel; bus.ext_bit_in = ext;
        #1;
        issue = 0; n = m_n; k = 0;
        if (ena && run && ep && m_state != 0) begin
            n     = (m_state == 1) ? 0 : m_n + 1;
            issue = (n % EPB) == 0;
            k     = (n / EPB) % WB;
        end
        if (issue && k == 0) begin sx = !up; ss = int'(sel); end
        else begin sx = m_ext; ss = m_sel; end
        req_seen = bus.bit_req_out;
        chk("bit_req", bus.bit_req_out, 32'(issue && sx));
        raw = sx ? ext : preset_bit(ss, k, m_bits);
        tx  = raw;
        p29 = 0; p30 = 0;
`ifdef NAV_PARITY_EN
        if (k < 24) tx = raw ^ m_d30;
        else tx = par_bit(k - 23);
        p29 = par_bit(5);
        p30 = par_bit(6);
`endif
        @(posedge clk); #1;
        if (ena) begin
            if (!run) begin
                model_reset();
            end else begin
                if (m_state == 0) m_state = 1;
                else if (ep) begin m_state = 2; m_n = n; end
                e_bs = issue;
                e_ws = issue && (k == 0);
                if (issue) begin
                    e_msg = tx; m_bits++; m_ext = sx; m_sel = ss;
`ifdef NAV_PARITY_EN
                    if (k < 24) m_d[k] = raw;
                    if (k == 29) begin m_d29 = p29; m_d30 = p30; end
`endif
                end
            end
        end else begin
            e_bs = 0; e_ws = 0;
        end
        chk("msg_out", bus.msg_out, 32'(e_msg));
        chk("bit_strobe", bus.bit_strobe_out, 32'(e_bs));
        chk("word_strobe", bus.word_strobe_out, 32'(e_ws));
    endtask

    task automatic run_qe(input int gap);
        for (int i = 1; i < gap; i++) cyc(1, g_run, 0, g_up, g_sel, g_ext);
        cyc(1, g_run, 1, g_up, g_sel, g_ext);
    endtask

    task automatic do_reset();
        rst = 1;
        bus.ena_in = 0; bus.run_in = 0; bus.epoch_in = 0;
        bus.use_msg_preset_in = 0; bus.preset_sel_in = 0; bus.ext_bit_in = 0;
        @(posedge clk); #1;
        chk("rst_msg", bus.msg_out, 0);
        chk("rst_bs", bus.bit_strobe_out, 0);
        chk("rst_ws", bus.word_strobe_out, 0);
        rst = 0;
        model_reset();
    endtask

    // reset, select the source, and take one cycle to reach SYNC
    task automatic start(input bit up, input logic [1:0] sel, input bit ext);
        do_reset();
        g_up = up; g_sel = sel; g_ext = ext; g_run = 1;
        cyc(1, 1, 0, g_up, g_sel, g_ext);
    endtask

    typedef struct {
        bit         up;
        logic [1:0] sel;
        bit         ext;
        logic [7:0] exp;   // first 8 transmitted bits, bit k at index k
    } vec_t;

    vec_t vecs [6];

    initial begin
        int cnt, idx, guard, reqs;
        bit sampled;
        logic [7:0] got;
        bit wbits [40];

        vecs[0] = '{1'b1, 2'd0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 2'd1, 1'b0, 8'h55};
        vecs[2] = '{1'b1, 2'd2, 1'b0, 8'hD1};
        vecs[3] = '{1'b1, 2'd3, 1'b0, 8'hFF};
        vecs[4] = '{1'b0, 2'd0, 1'b1, 8'hFF};
        vecs[5] = '{1'b0, 2'd2, 1'b0, 8'h00};
        g_up = 1; g_sel = 0; g_ext = 0; g_run = 0;

        // Preset 1, qe every 4 cycles: first bit one cycle after first qe,
        // next bit exactly 20 qe later.
        start(1, 2'd1, 0);
        run_qe(4);
        chk("t1_first_strobe", bus.bit_strobe_out, 1);
        chk("t1_first_msg", bus.msg_out, 1);
        cnt = 0;
        do begin run_qe(4); cnt++; end while (!bus.bit_strobe_out && cnt < 100);
        chk("t1_qe_per_bit", cnt, EPB);
        chk("t1_second_msg", bus.msg_out, 0);

        // Vector table: first 8 bits of each source.
        foreach (vecs[v]) begin
            start(vecs[v].up, vecs[v].sel, vecs[v].ext);
            got = '0; idx = 0; guard = 0;
            while (idx < 8 && guard < 400) begin
                run_qe(1); guard++;
                if (bus.bit_strobe_out) begin got[idx] = bus.msg_out; idx++; end
            end
            chk("vec_nbits", idx, 8);
            chk($sformatf("vec%0d_bits", v), got, vecs[v].exp);
        end

        // Word period for preset 2: 600 qe between word strobes.
        start(1, 2'd2, 0);
        run_qe(1);
        chk("t2_first_ws", bus.word_strobe_out, 1);
        cnt = 0;
        do begin run_qe(1); cnt++; end while (!bus.word_strobe_out && cnt < 1000);
        chk("t2_qe_per_word", cnt, EPB * WB);

        // External source, alternating bits.
        start(0, 2'd0, 0);
        reqs = 0;
        for (int i = 0; i < 3 * EPB; i++) begin
            sampled = g_ext;
            run_qe(2);
            if (req_seen) begin
                reqs++;
                chk("t3_msg_eq_sample", bus.msg_out, 32'(sampled));
                g_ext = ~g_ext;
            end
        end
        chk("t3_req_count", reqs, 3);

        // Preset change mid-word takes effect at the next word.
        start(1, 2'd1, 0);
        idx = 0; guard = 0;
        while (idx < WB + 8 && guard < 2000) begin
            run_qe(1); guard++;
            if (bus.bit_strobe_out) begin
                wbits[idx] = bus.msg_out; idx++;
                if (idx == 5) g_sel = 2'd2;
            end
        end
        chk("t4_nbits", idx, WB + 8);
        for (int k = 5; k < 24; k++) chk("t4_old_word", 32'(wbits[k]), 32'((k % 2) == 0));
        for (int k = 0; k < 8; k++) chk("t4_new_word", 32'(wbits[WB + k]), 32'(pre_tab[k] ^ int'(m_d30)));

        // run_in dropped together with qe mid-bit, then restart.
        start(1, 2'd1, 0);
        for (int i = 0; i < 8; i++) run_qe(1);
        chk("t5_msg_before", bus.msg_out, 1);
        g_run = 0;
        cyc(1, 0, 1, g_up, g_sel, g_ext);
        chk("t5_abort_msg", bus.msg_out, 0);
        chk("t5_abort_bs", bus.bit_strobe_out, 0);
        g_run = 1;
        cyc(1, 1, 0, g_up, g_sel, g_ext);
        run_qe(3);
        chk("t5_restart_ws", bus.word_strobe_out, 1);
        chk("t5_restart_msg", bus.msg_out, 1);

        // Asynchronous reset mid-word, then IDLE for a cycle despite run_in.
        start(1, 2'd1, 0);
        run_qe(1);
        #2 rst = 1;
        #1;
        chk("t6_async_msg", bus.msg_out, 0);
        chk("t6_async_bs", bus.bit_strobe_out, 0);
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        cyc(1, 1, 1, 1, 2'd1, 0);
        chk("t6_idle_after_rst", bus.bit_strobe_out, 0);
        run_qe(1);
        chk("t6_restart_bs", bus.bit_strobe_out, 1);

        // PN9 over more than a word.
        start(1, 2'd3, 0);
        for (int i = 0; i < 40 * EPB; i++) run_qe(1);

`ifdef NAV_PARITY_EN
        // All-zero data gives zero parity.
        start(1, 2'd0, 0);
        idx = 0; guard = 0;
        while (idx < WB && guard < 1000) begin
            run_qe(1); guard++;
            if (bus.bit_strobe_out) begin wbits[idx] = bus.msg_out; idx++; end
        end
        for (int k = 24; k < WB; k++) chk("par_zero", 32'(wbits[k]), 0);
        // Preset 2 words against the parity model, carrying D29*/D30*.
        start(1, 2'd2, 0);
        for (int i = 0; i < 2 * WB * EPB + 5; i++) run_qe(1);
`endif

        // Randomized run against the model.
        start(1, 2'd0, 0);
        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2999) != 0,
                $urandom_range(0, 1) == 0, 1'($urandom), 2'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
